// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's request/acknowledge and per-domain reset outputs.
// The sequencer uses the slave side; whoever requests soft re-sequences uses the master side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  soft_req;
  logic                  soft_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  ready;

  modport master (
    output soft_req,
    input  soft_ack,
    input  stage_rst_n,
    input  ready
  );

  modport slave (
    input  soft_req,
    output soft_ack,
    output stage_rst_n,
    output ready
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains in reset, then release them one by one in
// ascending order. A soft request drains the domains back into reset in descending order.
module reset_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYC   = 8,
  parameter int STAGE_DLY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  localparam int MAX_CYC = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Terminal counts are one less than the cycle counts: the counter starts at 0 on entry.
  localparam logic [CW-1:0]         HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]         DLY_LAST  = CW'(STAGE_DLY - 1);
  localparam logic [NUM_STAGES-1:0] ALL_REL   = '1;
  localparam logic [NUM_STAGES-1:0] ONLY_LOW  = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  soft_ack_q, soft_ack_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      soft_ack_q <= soft_ack_d;
    end
  end

  // stage_q is always a thermometer code, so release is a shift-in of a one from the
  // bottom and drain is a shift-out from the top: exactly one bit moves per edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    ready_d    = ready_q;
    soft_ack_d = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          stage_d = {stage_q[NUM_STAGES-2:0], 1'b1};
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RELEASE: begin
        if (cnt_q == DLY_LAST) begin
          cnt_d = '0;
          if (stage_q == ALL_REL) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end else begin
            stage_d = {stage_q[NUM_STAGES-2:0], 1'b1};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RUN: begin
        if (bus.soft_req) begin
          ready_d = 1'b0;
          stage_d = stage_q >> 1;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        stage_d = stage_q >> 1;
        if (stage_q == ONLY_LOW) begin
          cnt_d      = '0;
          soft_ack_d = 1'b1;
          state_d    = S_HOLD;
        end
      end

      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign bus.stage_rst_n = stage_q;
  assign bus.ready       = ready_q;
  assign bus.soft_ack    = soft_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default-parameter sequencer (A) and a minimal 2-stage, 1-cycle one (B),
// with the thermometer/one-bit-step/ready invariants checked at every sampled cycle.
module tb_reset_sequencer;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_b = 8'h00;
  bit         skip_a = 1'b0;

  int acks;
  int rdys;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(4)) bus_a ();
  reset_sequencer_if #(.NUM_STAGES(2)) bus_b ();

  reset_sequencer #(.NUM_STAGES(4), .HOLD_CYC(8), .STAGE_DLY(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  reset_sequencer #(.NUM_STAGES(2), .HOLD_CYC(1), .STAGE_DLY(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Thermometer shape, single-bit movement between samples, and ready only when all released.
  task automatic inv(input string tag, input logic [7:0] prev, input logic [7:0] cur,
                     input logic rdy, input logic [7:0] full, input bit skip);
    logic [7:0] inc;
    inc = cur + 8'd1;
    chk($sformatf("%s_thermo", tag), 32'((cur & inc) == 8'h00), 32'd1);
    if (!skip)
      chk($sformatf("%s_onebit", tag), 32'($countones(prev ^ cur) <= 1), 32'd1);
    chk($sformatf("%s_ready_all", tag), 32'(!rdy || (cur == full)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    inv("A", prev_a, {4'b0, bus_a.stage_rst_n}, bus_a.ready, 8'h0F, skip_a);
    inv("B", prev_b, {6'b0, bus_b.stage_rst_n}, bus_b.ready, 8'h03, 1'b0);
    prev_a = {4'b0, bus_a.stage_rst_n};
    prev_b = {6'b0, bus_b.stage_rst_n};
    skip_a = 1'b0;
  endtask

  // Defaults: stage k released at edge 8+4k, ready at edge 24.
  function automatic logic [3:0] exp_stage_a(input int e);
    int n;
    logic [7:0] t;
    if (e < 8) n = 0;
    else       n = (e - 8) / 4 + 1;
    if (n > 4) n = 4;
    t = (8'd1 << n) - 8'd1;
    return t[3:0];
  endfunction

  task automatic run_seq_a(input string tag, input int last_e);
    for (int e = 1; e <= last_e; e++) begin
      step();
      chk($sformatf("%s_stage_e%0d", tag, e), 32'(bus_a.stage_rst_n), 32'(exp_stage_a(e)));
      chk($sformatf("%s_ready_e%0d", tag, e), 32'(bus_a.ready), 32'(e >= 24));
      chk($sformatf("%s_ack_e%0d", tag, e), 32'(bus_a.soft_ack), 32'd0);
    end
  endtask

  initial begin
    bus_a.soft_req = 1'b0;
    bus_b.soft_req = 1'b1;

    // Held in reset for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_stage", 32'(bus_a.stage_rst_n), 32'h0);
      chk("rst_ready", 32'(bus_a.ready), 32'd0);
      chk("rst_ack", 32'(bus_a.soft_ack), 32'd0);
    end
    #1 rst_a = 1'b0;

    run_seq_a("boot", 24);
    step();
    chk("run_hold_ready", 32'(bus_a.ready), 32'd1);

    // Single-cycle soft request
    bus_a.soft_req = 1'b1;
    step();
    chk("drain0_stage", 32'(bus_a.stage_rst_n), 32'h7);
    chk("drain0_ready", 32'(bus_a.ready), 32'd0);
    bus_a.soft_req = 1'b0;
    step();
    chk("drain1_stage", 32'(bus_a.stage_rst_n), 32'h3);
    chk("drain1_ack", 32'(bus_a.soft_ack), 32'd0);
    step();
    chk("drain2_stage", 32'(bus_a.stage_rst_n), 32'h1);
    chk("drain2_ack", 32'(bus_a.soft_ack), 32'd0);
    step();
    chk("drain3_stage", 32'(bus_a.stage_rst_n), 32'h0);
    chk("drain3_ack", 32'(bus_a.soft_ack), 32'd1);
    run_seq_a("resoft", 24);

    // Continuous soft request: each pass is 28 edges
    bus_a.soft_req = 1'b1;
    acks = 0;
    rdys = 0;
    for (int e = 1; e <= 56; e++) begin
      step();
      acks += int'(bus_a.soft_ack);
      rdys += int'(bus_a.ready);
      if (e == 4 || e == 32) chk($sformatf("cont_ack_e%0d", e), 32'(bus_a.soft_ack), 32'd1);
      if (e == 28) chk("cont_ready_e28", 32'(bus_a.ready), 32'd1);
    end
    chk("cont_ack_count", 32'(acks), 32'd2);
    chk("cont_ready_count", 32'(rdys), 32'd2);
    bus_a.soft_req = 1'b0;
    step();
    chk("cont_stop_ready", 32'(bus_a.ready), 32'd1);
    chk("cont_stop_stage", 32'(bus_a.stage_rst_n), 32'hF);

    // Asynchronous reset from RUN, then again mid-RELEASE
    #1 rst_a = 1'b1;
    skip_a = 1'b1;
    #1;
    chk("async_run_stage", 32'(bus_a.stage_rst_n), 32'h0);
    chk("async_run_ready", 32'(bus_a.ready), 32'd0);
    rst_a = 1'b0;
    run_seq_a("pre_mid", 12);
    chk("mid_release_stage", 32'(bus_a.stage_rst_n), 32'h3);
    #1 rst_a = 1'b1;
    skip_a = 1'b1;
    #1;
    chk("async_mid_stage", 32'(bus_a.stage_rst_n), 32'h0);
    chk("async_mid_ready", 32'(bus_a.ready), 32'd0);
    chk("async_mid_ack", 32'(bus_a.soft_ack), 32'd0);
    rst_a = 1'b0;
    run_seq_a("rst_restart", 24);

    // Minimal configuration, soft_req high through HOLD and RELEASE
    #1 rst_b = 1'b0;
    step();
    chk("b_e1_stage", 32'(bus_b.stage_rst_n), 32'h1);
    chk("b_e1_ready", 32'(bus_b.ready), 32'd0);
    step();
    chk("b_e2_stage", 32'(bus_b.stage_rst_n), 32'h3);
    chk("b_e2_ready", 32'(bus_b.ready), 32'd0);
    step();
    chk("b_e3_stage", 32'(bus_b.stage_rst_n), 32'h3);
    chk("b_e3_ready", 32'(bus_b.ready), 32'd1);
    step();
    chk("b_e4_stage", 32'(bus_b.stage_rst_n), 32'h1);
    chk("b_e4_ready", 32'(bus_b.ready), 32'd0);
    bus_b.soft_req = 1'b0;
    step();
    chk("b_e5_stage", 32'(bus_b.stage_rst_n), 32'h0);
    chk("b_e5_ack", 32'(bus_b.soft_ack), 32'd1);
    step();
    chk("b_e6_stage", 32'(bus_b.stage_rst_n), 32'h1);
    chk("b_e6_ack", 32'(bus_b.soft_ack), 32'd0);
    step();
    chk("b_e7_stage", 32'(bus_b.stage_rst_n), 32'h3);
    step();
    chk("b_e8_ready", 32'(bus_b.ready), 32'd1);
    chk("a_still_run", 32'(bus_a.ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
